uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_tx_buf_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 80 ++++++++
 rtl/uart_tx_buf.sv | 156 +++++++++++++++
 tb/tb_uart_tx_buf.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buf_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding,
// default timing/depth constants and frame geometry.
package uart_tx_buf_pkg;

    // Transmitter FSM states; encoding is fixed so it can be probed externally.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // 50 MHz system clock at 115200 baud.
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned DEFAULT_FIFO_DEPTH   = 16;

    // Baud counter width; wide enough for the slowest legal bit period.
    localparam int unsigned BAUD_CNT_W = 16;

    // 8N1 framing.
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_CNT_W = 3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with an asynchronous-read (distributed) storage array.
// Pushes at full are ignored even when a pop happens in the same cycle, so the
// caller sees a simple "count < DEPTH" acceptance rule.
module uart_tx_fifo
    import uart_tx_buf_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic [DATA_BITS-1:0]    wdata_i,
    input  logic                    pop_i,
    output logic [DATA_BITS-1:0]    rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push_ok;
    logic pop_ok;

    // Acceptance is decided on the registered count only.
    assign push_ok = push_i && (count_q != FULL_CNT);
    assign pop_ok  = pop_i  && (count_q != '0);

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset discards contents by emptying the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop FSM
// with a registered, glitch-free serial output. Back-to-back frames are
// chained straight from STOP into START with no idle bit in between.
module uart_tx_buf
    import uart_tx_buf_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_strobe,
    output logic                 tx_232,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic                 tx_overflow
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);

    tx_state_e               state_q, state_d;
    logic [BAUD_CNT_W-1:0]   baud_q, baud_d;
    logic [BIT_CNT_W-1:0]    bit_q, bit_d;
    logic [DATA_BITS-1:0]    shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    ovf_q, ovf_d;

    logic                    fifo_pop;
    logic [DATA_BITS-1:0]    fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic                    bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (tx_strobe),
        .wdata_i (tx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Last cycle of the current bit period.
    assign bit_end = (baud_q == BAUD_LAST);

    // FSM next-state, baud/bit counters, shifter and FIFO pop decisions.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_CNT_W'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    // Chain directly into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Line level for the current state; registered below so the pin never glitches.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // Sticky overflow: any push presented while the FIFO is full was dropped.
    always_comb begin
        ovf_d = ovf_q | (tx_strobe & fifo_full);
    end

    // FSM, counters, shifter, output and overflow registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx_232      = tx_q;
    assign tx_full     = fifo_full;
    assign tx_empty    = (fifo_count == '0) && (state_q == IDLE);
    assign tx_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: stimulus predicts each accepted byte and
// its frame start time; a line receiver checks frames as they appear, and a
// status checker compares full/empty/overflow against the occupancy model.
module tb_uart_tx_buf;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int DC    = 434;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_strobe;
    logic       tx_232, tx_full, tx_empty, tx_overflow;

    logic [7:0] def_data;
    logic       def_strobe;
    logic       def_tx, def_full, def_empty, def_ovf;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    typedef struct { int acc; int pop; } ent_t;
    typedef struct { logic [7:0] d; int start; } exp_t;
    ent_t ents[$];
    exp_t sb[$];
    int   last_end = 0;
    int   ovf_edge = 32'h3FFF_FFFF;

    uart_tx_buf #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_strobe(tx_strobe),
        .tx_232(tx_232), .tx_full(tx_full), .tx_empty(tx_empty), .tx_overflow(tx_overflow)
    );

    uart_tx_buf dut_def (
        .clk(clk), .reset(reset), .tx_data(def_data), .tx_strobe(def_strobe),
        .tx_232(def_tx), .tx_full(def_full), .tx_empty(def_empty), .tx_overflow(def_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference model: a byte accepted at edge t is popped when the line is
    // free (t+1 if idle, else at the end of the previous frame); the FIFO
    // holds bytes accepted but not yet popped.
    function automatic int model_push(input logic [7:0] d, input int t);
        int occ;
        int p;
        occ = 0;
        foreach (ents[i]) if (ents[i].acc < t && ents[i].pop >= t) occ++;
        if (occ >= DEPTH) begin
            if (ovf_edge > t) ovf_edge = t;
            return -1;
        end
        p = (t + 1 > last_end) ? t + 1 : last_end;
        last_end = p + 10 * C;
        ents.push_back('{acc: t, pop: p});
        sb.push_back('{d: d, start: p + 1});
        return p;
    endfunction

    function automatic void model_clear();
        ents.delete();
        sb.delete();
        last_end = 0;
        ovf_edge = 32'h3FFF_FFFF;
    endfunction

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic drive_push(input logic [7:0] d, output int p);
        tx_data   = d;
        tx_strobe = 1'b1;
        p = model_push(d, edge_n + 1);
        $display("push data=0x%02h edge=%0d pop_edge=%0d", d, edge_n + 1, p);
        @(negedge clk);
        tx_strobe = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        chk("drain_pending", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Line receiver: collects 10 bit periods after a falling start edge.
    logic line_s [0:10*C-1];
    logic in_frame = 1'b0;
    int   nsamp    = 0;
    int   fstart   = 0;
    always @(negedge clk) begin
        if (!reset) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && tx_232 == 1'b0) begin
                in_frame = 1'b1;
                fstart   = edge_n;
                nsamp    = 0;
            end
            if (in_frame) begin
                line_s[nsamp] = tx_232;
                nsamp++;
                if (nsamp == 10 * C) begin
                    logic [7:0] got;
                    logic       shape_ok;
                    exp_t       e;
                    in_frame = 1'b0;
                    shape_ok = (line_s[9*C] === 1'b1);
                    for (int k = 0; k < 10; k++)
                        for (int j = 0; j < C; j++)
                            if (line_s[k*C+j] !== line_s[k*C]) shape_ok = 1'b0;
                    for (int k = 0; k < 8; k++) got[k] = line_s[(k+1)*C];
                    $display("frame data=0x%02h start=%0d shape_ok=%0d", got, fstart, shape_ok);
                    chk("frame_expected", (sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("frame_data", got, e.d);
                        chk("frame_start", fstart, e.start);
                        chk("frame_shape", shape_ok, 1);
                    end
                end
            end
        end
    end

    // Status checker: flags derived from model occupancy and busy windows.
    always @(negedge clk) begin
        int occ;
        logic busy;
        occ  = 0;
        busy = 1'b0;
        foreach (ents[i]) begin
            if (ents[i].acc <= edge_n && ents[i].pop > edge_n) occ++;
            if (ents[i].pop <= edge_n && edge_n < ents[i].pop + 10 * C) busy = 1'b1;
        end
        chk("tx_full", tx_full, (occ == DEPTH));
        chk("tx_empty", tx_empty, (occ == 0 && !busy));
        chk("tx_overflow", tx_overflow, (edge_n >= ovf_edge));
    end

    initial begin
        int p;
        int target;
        int run_len;
        int total;
        int exp_runs [6];
        logic lvl;

        exp_runs = '{DC, DC, 5*DC, DC, DC, DC};
        reset      = 1'b0;
        tx_strobe  = 1'b0;
        tx_data    = 8'h00;
        def_strobe = 1'b0;
        def_data   = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx232", tx_232, 1);
        chk("rst_def_tx232", def_tx, 1);
        chk("rst_def_empty", def_empty, 1);
        reset = 1'b1;
        @(negedge clk);

        // Single byte.
        drive_push(8'hA5, p);
        wait_drain(200);
        chk("single_idle_line", tx_232, 1);

        // Back-to-back frames.
        drive_push(8'h00, p);
        drive_push(8'hFF, p);
        drive_push(8'h55, p);
        wait_drain(400);

        // Push at full on the STOP-end pop edge.
        chk("pre_full_ovf", tx_overflow, 0);
        drive_push(8'h10, p);
        target = p + 10 * C;
        drive_push(8'h20, p);
        drive_push(8'h30, p);
        drive_push(8'h40, p);
        drive_push(8'h50, p);
        chk("full_before_pop", tx_full, 1);
        for (int i = 0; i < 200 && edge_n < target - 1; i++) @(negedge clk);
        drive_push(8'h77, p);
        chk("pushpop_dropped", p, -1);
        chk("pushpop_ovf", tx_overflow, 1);
        chk("pushpop_notfull", tx_full, 0);
        wait_drain(400);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        drive_push(8'h3C, p);
        target = p + 4 * C + 2;
        drive_push(8'h11, target);
        drive_push(8'h22, target);
        target = p + 4 * C + 2;
        for (int i = 0; i < 200 && edge_n < target; i++) @(negedge clk);
        chk("bit3_line", tx_232, 1);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_mid_tx232", tx_232, 1);
        chk("rst_mid_empty", tx_empty, 1);
        chk("rst_mid_ovf", tx_overflow, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30 * C + 10) @(negedge clk);
        chk("post_rst_empty", tx_empty, 1);
        chk("post_rst_line", tx_232, 1);

        // Overflow: six pushes while idle.
        for (int i = 1; i <= 6; i++) drive_push(8'(i), p);
        chk("ovf6_dropped", p, -1);
        chk("ovf6_full", tx_full, 1);
        chk("ovf6_flag", tx_overflow, 1);
        wait_drain(600);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) drive_push(8'($urandom), p);
            else @(negedge clk);
        end
        wait_drain(2000);

        // Default parameters: two back-to-back 0x41 frames, run lengths on the line.
        def_data   = 8'h41;
        def_strobe = 1'b1;
        repeat (2) @(negedge clk);
        def_strobe = 1'b0;
        for (int i = 0; i < 20 && def_tx != 1'b0; i++) @(negedge clk);
        chk("def_start_seen", def_tx, 0);
        total = 0;
        for (int r = 0; r < 6; r++) begin
            lvl = def_tx;
            run_len = 0;
            while (def_tx == lvl && run_len < 5000) begin
                run_len++;
                @(negedge clk);
            end
            $display("def run %0d level=%0d len=%0d", r, lvl, run_len);
            chk("def_run_len", run_len, exp_runs[r]);
            total += run_len;
        end
        chk("def_frame_width", total, 10 * DC);
        chk("def_next_start", def_tx, 0);
        repeat (10 * DC + 10) @(negedge clk);
        chk("def_empty_end", def_empty, 1);
        chk("def_line_end", def_tx, 1);
        chk("def_full_end", def_full, 0);
        chk("def_ovf_end", def_ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
